bpsk_ctrl: RTL and testbench

BPSK_CTRL -- requirements
Module: bpsk_ctrl

---
 rtl/bpsk_ctrl.sv | 146 ++++++++++++++
 tb/tb_bpsk_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_ctrl.sv
// BPSK modulation controller: paces a sine generator, takes one bit per symbol
// of SPS samples and emits the sine or its saturated negation per bit value.
module bpsk_ctrl #(
   parameter int unsigned SPS = 16,
   parameter int unsigned DW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    frame_len,
   input  logic          bit_in,
   input  logic          bit_valid,
   output logic          bit_ready,
   output logic          sine_en,
   input  logic          sine_rdy,
   input  logic [DW-1:0] sine_in,
   output logic [DW-1:0] mod_out,
   output logic          mod_valid,
   output logic          busy,
   output logic          done,
   output logic          underrun
);

   localparam int unsigned CW = $clog2(SPS);
   localparam logic [CW-1:0] CntLast = CW'(SPS - 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StWaitBit = 2'd1;
   localparam logic [1:0] StRun     = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   localparam logic [DW-1:0] SMin = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] SMax = {1'b0, {(DW-1){1'b1}}};

   logic [1:0]    state_q, state_d;
   logic [7:0]    bits_left_q, bits_left_d;
   logic [CW-1:0] sample_cnt_q, sample_cnt_d;
   logic          bit_q, bit_d;
   logic          underrun_q, underrun_d;
   logic [DW-1:0] mod_out_q, mod_out_d;
   logic          mod_valid_q, mod_valid_d;
   logic          done_q, done_d;

   logic          sym_end;
   logic          more_bits;
   logic          handshake;
   logic [DW-1:0] neg_sample;

   assign sym_end   = (state_q == StRun) && sine_rdy && (sample_cnt_q == CntLast);
   assign more_bits = bits_left_q > 8'd1;
   assign bit_ready = (state_q == StWaitBit) || (sym_end && more_bits);
   assign handshake = bit_valid && bit_ready;
   assign sine_en   = (state_q == StRun);
   assign busy      = (state_q != StIdle);

   assign mod_out   = mod_out_q;
   assign mod_valid = mod_valid_q;
   assign done      = done_q;
   assign underrun  = underrun_q;

   // Negating the most negative sample would wrap, so clamp it to full scale.
   assign neg_sample = (sine_in == SMin) ? SMax : (DW'(0) - sine_in);

   always_comb begin
      state_d      = state_q;
      bits_left_d  = bits_left_q;
      sample_cnt_d = sample_cnt_q;
      bit_d        = bit_q;
      underrun_d   = underrun_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               bits_left_d = frame_len;
               underrun_d  = 1'b0;
               state_d     = (frame_len == 8'd0) ? StDone : StWaitBit;
            end
         end
         StWaitBit: begin
            if (handshake) begin
               bit_d        = bit_in;
               sample_cnt_d = '0;
               state_d      = StRun;
            end
         end
         StRun: begin
            if (sine_rdy) begin
               if (sym_end) begin
                  bits_left_d  = bits_left_q - 8'd1;
                  sample_cnt_d = '0;
                  if (more_bits) begin
                     // A bit offered on the boundary keeps the carrier running seamlessly.
                     if (handshake) begin
                        bit_d = bit_in;
                     end else begin
                        underrun_d = 1'b1;
                        state_d    = StWaitBit;
                     end
                  end else begin
                     state_d = StDone;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + CW'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mod_valid_d = (state_q == StRun) && sine_rdy;
      mod_out_d   = mod_out_q;
      if (mod_valid_d) begin
         mod_out_d = bit_q ? sine_in : neg_sample;
      end
      done_d = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         bits_left_q  <= 8'd0;
         sample_cnt_q <= '0;
         bit_q        <= 1'b0;
         underrun_q   <= 1'b0;
         mod_out_q    <= '0;
         mod_valid_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bits_left_q  <= bits_left_d;
         sample_cnt_q <= sample_cnt_d;
         bit_q        <= bit_d;
         underrun_q   <= underrun_d;
         mod_out_q    <= mod_out_d;
         mod_valid_q  <= mod_valid_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_bpsk_ctrl.sv
// Bench for bpsk_ctrl: per-cycle behavioural model check plus directed scenarios
// with literal expectations on sample values, counts and timing.
module tb_bpsk_ctrl;

   localparam int SPS = 4;
   localparam int DW  = 16;
   localparam int MI = 0, MW = 1, MR = 2, MD = 3;

   logic          clk, rst, start, bit_in, bit_valid, bit_ready, sine_en, sine_rdy;
   logic [7:0]    frame_len;
   logic [DW-1:0] sine_in, mod_out;
   logic          mod_valid, busy, done, underrun;

   bpsk_ctrl #(.SPS(SPS), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .bit_in(bit_in),
      .bit_valid(bit_valid), .bit_ready(bit_ready), .sine_en(sine_en),
      .sine_rdy(sine_rdy), .sine_in(sine_in), .mod_out(mod_out),
      .mod_valid(mod_valid), .busy(busy), .done(done), .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus controls (written by the main process only)
   int         rdy_period = 1;
   int         phase = 0;
   int         sine_val = 0;
   logic [7:0] bits_v = 8'd0;
   int         idx = 0;
   int         avail = 0;
   logic       feed_en = 1'b0;

   // Monitor-owned observations
   logic          hs_seen = 1'b0;
   int            cyc_n = 0, n_samp = 0, n_done = 0, n_en = 0, n_ready = 0;
   int            last_valid_cyc = 0, last_done_cyc = 0, last_start_cyc = 0;
   logic [DW-1:0] samp [64];

   // Model state
   int            m_state = MI, m_left = 0, m_cnt = 0;
   logic          m_bit = 1'b0, m_under = 1'b0, m_valid = 1'b0, m_done = 1'b0;
   logic [DW-1:0] m_out = '0;

   task automatic cmp(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc_n);
      end
   endtask

   function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] s);
      int v;
      v = -int'($signed(s));
      if (v > 32767) v = 32767;
      return DW'(v);
   endfunction

   initial begin
      int   e_ready;
      logic n_valid, n_done_m;
      forever begin
         @(negedge clk);
         cyc_n++;
         if (!rst) begin
            m_state = MI; m_left = 0; m_cnt = 0; m_bit = 1'b0; m_under = 1'b0;
            m_out = '0; m_valid = 1'b0; m_done = 1'b0;
         end
         e_ready = (m_state == MW) ||
                   (m_state == MR && sine_rdy && m_cnt == SPS - 1 && m_left > 1);
         cmp("busy", busy, m_state != MI);
         cmp("sine_en", sine_en, m_state == MR);
         cmp("bit_ready", bit_ready, e_ready);
         cmp("mod_valid", mod_valid, m_valid);
         cmp("mod_out", int'($signed(mod_out)), int'($signed(m_out)));
         cmp("done", done, m_done);
         cmp("underrun", underrun, m_under);
         hs_seen = rst && bit_valid && bit_ready;
         if (rst) begin
            if (mod_valid) begin
               samp[n_samp % 64] = mod_out;
               n_samp++;
               last_valid_cyc = cyc_n;
            end
            if (done) begin n_done++; last_done_cyc = cyc_n; end
            if (sine_en) n_en++;
            if (bit_ready) n_ready++;
            if (start) last_start_cyc = cyc_n;
            n_valid = 1'b0;
            n_done_m = (m_state == MD);
            case (m_state)
               MI: if (start) begin
                  m_left = int'(frame_len);
                  m_under = 1'b0;
                  m_state = (frame_len == 8'd0) ? MD : MW;
               end
               MW: if (bit_valid) begin
                  m_bit = bit_in; m_cnt = 0; m_state = MR;
               end
               MR: if (sine_rdy) begin
                  n_valid = 1'b1;
                  m_out = m_bit ? sine_in : neg_sat(sine_in);
                  if (m_cnt == SPS - 1) begin
                     m_cnt = 0;
                     if (m_left > 1) begin
                        if (bit_valid) m_bit = bit_in;
                        else begin m_under = 1'b1; m_state = MW; end
                     end else begin
                        m_state = MD;
                     end
                     m_left--;
                  end else begin
                     m_cnt++;
                  end
               end
               default: m_state = MI;
            endcase
            m_valid = n_valid;
            m_done = n_done_m;
         end
      end
   end

   task automatic upd();
      sine_rdy  = (phase == 0);
      sine_in   = DW'(sine_val);
      bit_valid = feed_en && (idx < avail);
      bit_in    = (idx < 8) ? bits_v[idx] : 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      if (hs_seen) idx++;
      phase = (phase + 1) % rdy_period;
      start = 1'b0;
      upd();
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0 = n_done;
      for (int i = 0; i < budget && n_done == d0; i++) cyc();
      if (n_done == d0) cmp({nm, "_timeout"}, 0, 1);
   endtask

   task automatic setup_frame(input logic [7:0] bits, input int av, input int sv);
      bits_v = bits; idx = 0; avail = av; feed_en = 1'b1; sine_val = sv;
      upd();
   endtask

   initial begin
      int s0, d0, e0, r0;
      rst = 1'b0; start = 1'b0; frame_len = 8'd0;
      upd();
      cyc(); cyc();
      cmp("rst_busy", busy, 0);
      cmp("rst_mod_valid", mod_valid, 0);
      cmp("rst_mod_out", mod_out, 0);
      cmp("rst_bit_ready", bit_ready, 0);
      rst = 1'b1;
      cyc();

      // Two-bit frame, bits 1 then 0, continuous sine_rdy
      setup_frame(8'b01, 2, 1000);
      s0 = n_samp; d0 = n_done; e0 = n_en;
      frame_len = 8'd2; start = 1'b1;
      cyc();
      wait_done("t1", 60);
      cmp("t1_nsamp", n_samp - s0, 8);
      cmp("t1_sine_en_cycles", n_en - e0, 8);
      cmp("t1_ndone", n_done - d0, 1);
      cmp("t1_underrun", underrun, 0);
      cmp("t1_done_lag", last_done_cyc - last_valid_cyc, 1);
      for (int i = 0; i < 8; i++)
         cmp("t1_sample", int'($signed(samp[(s0 + i) % 64])), (i < 4) ? 1000 : -1000);
      feed_en = 1'b0; upd(); cyc();

      // Most negative sample negated saturates
      setup_frame(8'b00, 1, -32768);
      s0 = n_samp;
      frame_len = 8'd1; start = 1'b1;
      cyc();
      wait_done("t2", 40);
      cmp("t2_nsamp", n_samp - s0, 4);
      for (int i = 0; i < 4; i++)
         cmp("t2_sample", int'($signed(samp[(s0 + i) % 64])), 32767);
      feed_en = 1'b0; upd(); cyc();

      // Underrun after first symbol, gap, then resume
      setup_frame(8'b101, 1, 1000);
      s0 = n_samp; d0 = n_done;
      frame_len = 8'd3; start = 1'b1;
      cyc();
      for (int i = 0; i < 30 && underrun !== 1'b1; i++) cyc();
      cmp("t3_underrun_set", underrun, 1);
      cmp("t3_gap_sine_en", sine_en, 0);
      e0 = n_en;
      repeat (5) cyc();
      cmp("t3_gap_len", n_en - e0, 0);
      avail = 3; upd();
      wait_done("t3", 60);
      cmp("t3_nsamp", n_samp - s0, 12);
      cmp("t3_underrun_sticky", underrun, 1);
      cmp("t3_ndone", n_done - d0, 1);
      for (int i = 0; i < 12; i++)
         cmp("t3_sample", int'($signed(samp[(s0 + i) % 64])), (i / 4 == 1) ? -1000 : 1000);
      feed_en = 1'b0; upd(); cyc();

      // Zero-length frame
      setup_frame(8'b1, 1, 1000);
      s0 = n_samp; d0 = n_done; r0 = n_ready;
      frame_len = 8'd0; start = 1'b1;
      cyc();
      repeat (6) cyc();
      cmp("t4_done_latency", last_done_cyc - last_start_cyc, 2);
      cmp("t4_ndone", n_done - d0, 1);
      cmp("t4_nsamp", n_samp - s0, 0);
      cmp("t4_bit_ready", n_ready - r0, 0);
      cmp("t4_underrun_cleared", underrun, 0);
      feed_en = 1'b0; upd(); cyc();

      // Reset during the third sample of a symbol
      setup_frame(8'b01, 2, 1000);
      e0 = n_en;
      frame_len = 8'd2; start = 1'b1;
      cyc();
      for (int i = 0; i < 20 && (n_en - e0) < 2; i++) cyc();
      cmp("t5_pre_valid", mod_valid, 1);
      rst = 1'b0;
      #1;
      cmp("t5_rst_mod_valid", mod_valid, 0);
      cmp("t5_rst_mod_out", mod_out, 0);
      cmp("t5_rst_busy", busy, 0);
      cmp("t5_rst_sine_en", sine_en, 0);
      cmp("t5_rst_bit_ready", bit_ready, 0);
      cmp("t5_rst_done", done, 0);
      cmp("t5_rst_underrun", underrun, 0);
      cyc(); cyc();
      rst = 1'b1; feed_en = 1'b0; upd();
      cyc();
      s0 = n_samp;
      repeat (4) cyc();
      cmp("t5_no_residual", n_samp - s0, 0);
      frame_len = 8'd2; start = 1'b1;
      cyc();
      repeat (10) cyc();
      cmp("t5_wait_busy", busy, 1);
      cmp("t5_wait_ready", bit_ready, 1);
      cmp("t5_wait_sine_en", sine_en, 0);
      cmp("t5_nsamp", n_samp - s0, 0);
      rst = 1'b0; cyc(); rst = 1'b1; cyc();

      // Sparse sine_rdy with ignored start pulses mid-frame
      rdy_period = 3; phase = 0;
      setup_frame(8'b01, 2, 500);
      s0 = n_samp; d0 = n_done;
      frame_len = 8'd2; start = 1'b1;
      cyc();
      for (int i = 0; i < 120 && n_done == d0; i++) begin
         cyc();
         if (i == 5 || i == 12) begin frame_len = 8'd5; start = 1'b1; end
      end
      cmp("t6_ndone", n_done - d0, 1);
      cmp("t6_nsamp", n_samp - s0, 8);
      cmp("t6_done_lag", last_done_cyc - last_valid_cyc, 1);
      for (int i = 0; i < 8; i++)
         cmp("t6_sample", int'($signed(samp[(s0 + i) % 64])), (i < 4) ? 500 : -500);
      feed_en = 1'b0; upd();
      repeat (4) cyc();
      cmp("t6_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
